// File: rtl/inst_fetch_unit_pkg.sv
// Core-wide fetch definitions: state encodings, NOP word and default vectors.
package inst_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_TRAP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST             = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0040;

endpackage

// File: rtl/inst_fetch_unit_next_pc_sel.sv
// Combinational next-PC / next-state priority mux for the fetch stage.
module inst_fetch_unit_next_pc_sel
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned     ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR = ADDR_WIDTH'(DEFAULT_TRAP_VECTOR)
) (
  input  fetch_state_e          state,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  input  logic                  trap_ack,
  output logic [ADDR_WIDTH-1:0] next_pc,
  output fetch_state_e          next_state,
  output logic                  count_en
);

  always_comb begin
    next_pc    = pc;
    next_state = state;
    count_en   = 1'b0;
    case (state)
      FS_RUN: begin
        // A retiring branch wins over stall; a misaligned target parks in TRAP with the bad PC kept.
        if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
          next_state = FS_TRAP;
          next_pc    = redirect_target;
        end else if (redirect_valid) begin
          next_pc  = redirect_target;
          count_en = 1'b1;
        end else if (!stall) begin
          next_pc  = pc + ADDR_WIDTH'(4);
          count_en = 1'b1;
        end
      end
      FS_TRAP: begin
        if (trap_ack) begin
          next_pc    = TRAP_VECTOR;
          next_state = FS_BOOT;
        end
      end
      default: begin
        next_state = FS_RUN;
      end
    endcase
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, addresses the ROM and presents {pc, inst, valid} to decode.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           INST_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEFAULT_RESET_VECTOR),
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = ADDR_WIDTH'(DEFAULT_TRAP_VECTOR)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  input  logic                  trap_ack,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [INST_WIDTH-1:0] rom_data,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  inst_valid,
  output logic                  misalign_trap,
  output logic [31:0]           fetch_count
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           fetch_count_q;
  logic                  count_en;

  inst_fetch_unit_next_pc_sel #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .TRAP_VECTOR(TRAP_VECTOR)
  ) u_next_pc_sel (
    .state          (state_q),
    .pc             (pc_q),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .trap_ack       (trap_ack),
    .next_pc        (pc_d),
    .next_state     (state_d),
    .count_en       (count_en)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FS_BOOT;
      pc_q          <= RESET_VECTOR;
      fetch_count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (count_en) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
    end
  end

  assign rom_addr    = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + ADDR_WIDTH'(4);
  assign fetch_count = fetch_count_q;

  // Only RUN exposes ROM data; BOOT, TRAP and any stray encoding present a NOP bubble.
  always_comb begin
    inst          = INST_WIDTH'(NOP_INST);
    inst_valid    = 1'b0;
    misalign_trap = 1'b0;
    case (state_q)
      FS_RUN: begin
        inst       = rom_data;
        inst_valid = 1'b1;
      end
      FS_TRAP: begin
        misalign_trap = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed scoreboard bench for inst_fetch_unit: stimulus pushes expectations, monitor compares after each edge.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_ack;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] inst;
  logic        inst_valid;
  logic        misalign_trap;
  logic [31:0] fetch_count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        trap;
    logic [31:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   txn      = 0;

  logic [31:0] rom [0:63];

  inst_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .trap_ack       (trap_ack),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .inst           (inst),
    .inst_valid     (inst_valid),
    .misalign_trap  (misalign_trap),
    .fetch_count    (fetch_count)
  );

  assign rom_data = rom[rom_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL txn=%0d %s actual=%h required=%h", txn, name, act, req);
    end
  endtask

  // Drive one cycle of inputs and queue the state expected after the following edge.
  task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] rt,
                      input logic ta, input logic [31:0] e_pc, input logic [31:0] e_inst,
                      input logic e_v, input logic e_trap, input logic [31:0] e_fc);
    exp_t e;
    @(negedge clk);
    rst             = r;
    stall           = s;
    redirect_valid  = rv;
    redirect_target = rt;
    trap_ack        = ta;
    e.pc    = e_pc;
    e.inst  = e_inst;
    e.valid = e_v;
    e.trap  = e_trap;
    e.fc    = e_fc;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        chk("pc", pc, e.pc);
        chk("rom_addr", rom_addr, e.pc);
        chk("pc_plus4", pc_plus4, e.pc + 32'd4);
        chk("inst", inst, e.inst);
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, e.valid});
        chk("misalign_trap", {31'd0, misalign_trap}, {31'd0, e.trap});
        chk("fetch_count", fetch_count, e.fc);
        $display("txn %0d pc=%h inst=%h valid=%b trap=%b fc=%h",
                 txn, pc, inst, inst_valid, misalign_trap, fetch_count);
      end
    end
  end

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    int wait_cycles;
    for (int i = 0; i < 64; i++) rom[i] = 32'h1000 + i;
    rom[0]  = 32'h11;
    rom[1]  = 32'h22;
    rom[2]  = 32'h33;
    rom[3]  = 32'h44;
    rom[8]  = 32'h88;
    rom[9]  = 32'h99;
    rom[16] = 32'h400;
    rom[17] = 32'h440;
    rom[63] = 32'hFC;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0; trap_ack = 1'b0;

    // Reset, BOOT bubble, free-run
    step(1, 0, 0, 32'h0, 0, 32'h00, NOP,   0, 0, 0);
    step(1, 0, 0, 32'h0, 0, 32'h00, NOP,   0, 0, 0);
    step(0, 0, 0, 32'h0, 0, 32'h00, 32'h11, 1, 0, 0);
    step(0, 0, 0, 32'h0, 0, 32'h04, 32'h22, 1, 0, 1);
    step(0, 0, 0, 32'h0, 0, 32'h08, 32'h33, 1, 0, 2);
    // Stall three cycles at 0x8, then release
    step(0, 1, 0, 32'h0, 0, 32'h08, 32'h33, 1, 0, 2);
    step(0, 1, 0, 32'h0, 0, 32'h08, 32'h33, 1, 0, 2);
    step(0, 1, 0, 32'h0, 0, 32'h08, 32'h33, 1, 0, 2);
    step(0, 0, 0, 32'h0, 0, 32'h0C, 32'h44, 1, 0, 3);
    // Redirect overrides stall
    step(0, 1, 1, 32'h20, 0, 32'h20, 32'h88, 1, 0, 4);
    step(0, 0, 0, 32'h0,  0, 32'h24, 32'h99, 1, 0, 5);
    // Misaligned redirect, ignored inputs in TRAP, trap_ack recovery
    step(0, 0, 1, 32'h22, 0, 32'h22, NOP,    0, 1, 5);
    step(0, 0, 1, 32'h30, 0, 32'h22, NOP,    0, 1, 5);
    step(0, 1, 0, 32'h0,  0, 32'h22, NOP,    0, 1, 5);
    step(0, 0, 0, 32'h0,  1, 32'h40, NOP,    0, 0, 5);
    step(0, 0, 0, 32'h0,  0, 32'h40, 32'h400, 1, 0, 5);
    step(0, 0, 0, 32'h0,  0, 32'h44, 32'h440, 1, 0, 6);
    // Reset mid-stall
    step(0, 1, 0, 32'h0,  0, 32'h44, 32'h440, 1, 0, 6);
    step(1, 1, 0, 32'h0,  0, 32'h00, NOP,    0, 0, 0);
    step(0, 0, 0, 32'h0,  0, 32'h00, 32'h11, 1, 0, 0);
    step(0, 0, 0, 32'h0,  0, 32'h04, 32'h22, 1, 0, 1);
    // Reset mid-TRAP
    step(0, 0, 1, 32'h05, 0, 32'h05, NOP,    0, 1, 1);
    step(1, 0, 0, 32'h0,  0, 32'h00, NOP,    0, 0, 0);
    step(0, 0, 0, 32'h0,  0, 32'h00, 32'h11, 1, 0, 0);
    // PC and fetch_count wrap-around
    step(0, 0, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 32'hFC, 1, 0, 1);
    @(posedge clk);
    #2;
    dut.fetch_count_q = 32'hFFFF_FFFF;
    step(0, 0, 0, 32'h0, 0, 32'h00, 32'h11, 1, 0, 0);
    step(0, 0, 0, 32'h0, 0, 32'h04, 32'h22, 1, 0, 1);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
